line_fill_controller: RTL and testbench
=======================================

Name: line_fill_controller

Overview:
Initiator side of the 256-bit physical-memory handshake. It serves one cache miss at a time from the cache controller. On a dirty miss it first writes back the victim line, then fetches the missed line. The fetched line is returned to the cache with a one-cycle done pulse. The block sits between the cache datapath/control and physical memory.

Parameters:
ADDR_W, 16, byte-address width of request and memory address.
LINE_W, 256, cache line width in bits.
OFFSET_W, 5, line-offset bits forced to zero on the memory address.
TIMEOUT, 1024, cycles to wait for pmem_resp before aborting with an error.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  miss request present.
req_ready  out  1  controller idle; a request is accepted on a cycle where req_valid & req_ready.
req_addr  in  ADDR_W  byte address of the missed line.
req_dirty  in  1  victim line needs writeback.
req_victim_addr  in  ADDR_W  byte address of the victim line.
req_victim_data  in  LINE_W  victim line data.
done  out  1  one-cycle pulse; fill_data is valid on that cycle.
fill_data  out  LINE_W  fetched line, held until the next accept.
err  out  1  sticky timeout flag; cleared only by rst.
pmem_read  out  1  memory read strobe.
pmem_write  out  1  memory write strobe.
pmem_address  out  ADDR_W  line-aligned address.
pmem_wdata  out  LINE_W  writeback data.
pmem_resp  in  1  memory completion, single-cycle pulse.
pmem_rdata  in  LINE_W  read data, valid while pmem_resp=1.

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - done=0, fill_data=0, err=0, timer=0.
  - req_ready=1 once IDLE is reached.
- All outputs are registered except req_ready, which is decoded from state==IDLE.
- On accept, the controller latches req_addr, req_dirty, req_victim_addr and req_victim_data. Later changes on the request inputs are ignored.
- States:
  - IDLE:
    - On accept with dirty=1, go to WB: pmem_write=1, pmem_address={victim_addr[ADDR_W-1:5],5'b0}, pmem_wdata=victim data.
    - On accept with dirty=0, go to FILL: pmem_read=1, pmem_address={addr[ADDR_W-1:5],5'b0}.
  - WB: strobe and address/data are held stable until pmem_resp=1 is sampled. Then pmem_write=0 and go to GAP.
  - GAP: exactly one cycle with both strobes low (memory returns to idle). Then assert pmem_read with the fill address and go to FILL.
  - FILL: hold until pmem_resp=1. Then capture fill_data<=pmem_rdata, pmem_read=0, done<=1, go to DONE.
  - DONE: done drops to 0 the next cycle and the state returns to IDLE. The earliest next accept is the cycle after DONE.
- Strobe rules:
  - pmem_read and pmem_write are never high together.
  - Each strobe is deasserted in the cycle immediately after the resp edge.
- Latency, with memory response latency L cycles from strobe to resp:
  - clean miss: done = accept + L + 1.
  - dirty miss: done = accept + 2L + 2.
- Timer:
  - Cleared on entering WB or FILL; increments each cycle in WB or FILL while pmem_resp=0.
  - On timer==TIMEOUT-1 without resp: err<=1, strobes drop, return to IDLE without a done pulse, fill_data unchanged.
- pmem_resp sampled in IDLE, GAP or DONE (stray or late response) is ignored.
- A reset mid-transaction abandons the access. A resp arriving after reset lands in IDLE and is ignored.
- The request must not assert req_valid for a line already being processed; no hazard checking is done.

Decomposition:
- Package line_fill_pkg:
  - enum fill_state_t {IDLE, WB, GAP, FILL, DONE}.
  - localparams LINE_W, ADDR_W, OFFSET_W.
  - function line_align(addr), which zeroes the offset bits.
- Sub-module fill_timeout_timer (counter, clear, enable, expired output) is natural.
- FSM, request latch and memory-interface registers stay in the top module.

Test Plan:
1. Clean miss, req_addr=16'h1234, memory latency 5 -> pmem_read=1 with pmem_address=16'h1220 and pmem_write never high; done pulses 1 cycle at accept+6; fill_data equals the memory line at 0x1220.
2. Dirty miss, victim_addr=16'h8040 with data 0xA5..A5, req_addr=16'h0060 -> write to 0x8040 first; then exactly one cycle with both strobes low; then read of 0x0060; done at accept+2L+2; memory at 0x8040 reads back 0xA5..A5.
3. Back-to-back: req_valid held high with two different addresses -> second accepted only after DONE (req_ready=0 throughout); both lines returned in order.
4. Timeout: responder never asserts pmem_resp, TIMEOUT=16 -> strobe drops after 16 cycles, err=1 sticky, no done, req_ready=1; the next clean miss still completes.
5. Async reset asserted mid-FILL -> strobes, done and fill_data clear without waiting for clk. A late pmem_resp after release is ignored; no done.
6. Request inputs changed after accept -> pmem_address and pmem_wdata keep the latched values until resp.

Source files
------------

// File: rtl/line_fill_pkg.sv
// Shared types and constants for the line fill controller.
// The memory bus carries whole cache lines; addresses are always line-aligned.
package line_fill_pkg;

  localparam int ADDR_W   = 16;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WB   = 3'd1,
    GAP  = 3'd2,
    FILL = 3'd3,
    DONE = 3'd4
  } fill_state_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] mask;
    mask = '1;
    mask[OFFSET_W-1:0] = '0;
    return addr & mask;
  endfunction

endpackage

// File: rtl/fill_timeout_timer.sv
// Per-access watchdog: counts cycles spent waiting for a memory response.
// expired is high while the count sits at TIMEOUT-1; the count saturates there.
module fill_timeout_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/line_fill_controller.sv
// Serves one cache miss at a time: optional victim writeback, one idle bus
// cycle, then the line fetch, returned with a single-cycle done pulse.
module line_fill_controller
  import line_fill_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  // Request handshake: a miss is taken on any rising edge where
  // req_valid && req_ready; the request fields are only sampled then.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_dirty,
  input  logic [ADDR_W-1:0] req_victim_addr,
  input  logic [LINE_W-1:0] req_victim_data,
  output logic              done,
  output logic [LINE_W-1:0] fill_data,
  output logic              err,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic [2:0]        state_dbg
);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_lat, addr_lat_d;
  logic              read_d, write_d, done_d, err_d;
  logic [ADDR_W-1:0] address_d;
  logic [LINE_W-1:0] wdata_d, fill_d;
  logic              timer_clear, timer_en, timer_expired;

  assign req_ready = (state_q == IDLE);
  assign state_dbg = state_q;

  fill_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_lat_d  = addr_lat;
    read_d      = pmem_read;
    write_d     = pmem_write;
    address_d   = pmem_address;
    wdata_d     = pmem_wdata;
    done_d      = 1'b0;
    fill_d      = fill_data;
    err_d       = err;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_lat_d  = req_addr;
          timer_clear = 1'b1;
          if (req_dirty) begin
            state_d   = WB;
            write_d   = 1'b1;
            address_d = line_align(req_victim_addr);
            wdata_d   = req_victim_data;
          end else begin
            state_d   = FILL;
            read_d    = 1'b1;
            address_d = line_align(req_addr);
          end
        end
      end

      WB: begin
        if (pmem_resp) begin
          write_d = 1'b0;
          state_d = GAP;
        end else if (timer_expired) begin
          write_d = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end

      // Both strobes stay low for this one cycle so memory sees a clean turnaround.
      GAP: begin
        read_d      = 1'b1;
        address_d   = line_align(addr_lat);
        timer_clear = 1'b1;
        state_d     = FILL;
      end

      FILL: begin
        if (pmem_resp) begin
          read_d  = 1'b0;
          fill_d  = pmem_rdata;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (timer_expired) begin
          read_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_lat     <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      done         <= 1'b0;
      fill_data    <= '0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_lat     <= addr_lat_d;
      pmem_read    <= read_d;
      pmem_write   <= write_d;
      pmem_address <= address_d;
      pmem_wdata   <= wdata_d;
      done         <= done_d;
      fill_data    <= fill_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_line_fill_controller.sv
// Directed bench for line_fill_controller against a behavioural line memory
// with programmable response latency.
module tb_line_fill_controller;

  localparam int AW = 16;
  localparam int LW = 256;

  logic          clk, rst;
  logic          req_valid, req_ready, req_dirty;
  logic [AW-1:0] req_addr, req_victim_addr;
  logic [LW-1:0] req_victim_data;
  logic          done, err;
  logic [LW-1:0] fill_data;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;
  logic [2:0]    state_dbg;

  line_fill_controller #(.TIMEOUT(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_dirty       (req_dirty),
    .req_victim_addr (req_victim_addr),
    .req_victim_data (req_victim_data),
    .done            (done),
    .fill_data       (fill_data),
    .err             (err),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_resp       (pmem_resp),
    .pmem_rdata      (pmem_rdata),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents before any write: a pattern derived from the line address.
  function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
    return {8{a, ~a}};
  endfunction

  // ---------------- memory responder ----------------
  logic [LW-1:0] mem [logic [AW-1:0]];
  int            mem_lat = 1;
  int            mem_cnt = 0;
  bit            mem_en = 1'b1;
  bit            manual_resp = 1'b0;

  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = manual_resp;
      if ((pmem_read || pmem_write) && mem_en) begin
        mem_cnt++;
        if (mem_cnt == mem_lat) begin
          pmem_resp = 1'b1;
          mem_cnt   = 0;
          if (pmem_write) mem[pmem_address] = pmem_wdata;
          else pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : pat(pmem_address);
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // ---------------- driver / observer ----------------
  int            o_lat, o_wr_cycles, o_rd_cycles, o_gap;
  logic [LW-1:0] o_fill;
  logic [AW-1:0] o_wr_addr, o_rd_addr;
  bit            o_done_after, o_overlap, o_order_bad, o_wr_unstable, o_rd_unstable, o_wdata_bad;
  bit            o_ready_before;

  task automatic run_txn(input logic dirty, input logic [AW-1:0] addr, input logic [AW-1:0] vaddr,
                         input logic [LW-1:0] vdata, input int lat);
    @(negedge clk);
    mem_lat         = lat;
    req_dirty       = dirty;
    req_addr        = addr;
    req_victim_addr = vaddr;
    req_victim_data = vdata;
    req_valid       = 1'b1;
    o_ready_before  = req_ready;
    @(posedge clk);
    #1;
    req_valid       = 1'b0;
    req_addr        = addr ^ 16'hBAD0;
    req_victim_addr = ~vaddr;
    req_victim_data = ~vdata;
    req_dirty       = ~dirty;
    o_lat = -1; o_fill = '0; o_wr_cycles = 0; o_rd_cycles = 0; o_gap = 0;
    o_wr_addr = '0; o_rd_addr = '0; o_done_after = 1'b1;
    o_overlap = 0; o_order_bad = 0; o_wr_unstable = 0; o_rd_unstable = 0; o_wdata_bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (pmem_read && pmem_write) o_overlap = 1;
      if (pmem_write) begin
        if (o_wr_cycles == 0) o_wr_addr = pmem_address;
        else if (pmem_address != o_wr_addr) o_wr_unstable = 1;
        if (pmem_wdata != vdata) o_wdata_bad = 1;
        if (o_rd_cycles > 0) o_order_bad = 1;
        o_wr_cycles++;
      end
      if (pmem_read) begin
        if (o_rd_cycles == 0) o_rd_addr = pmem_address;
        else if (pmem_address != o_rd_addr) o_rd_unstable = 1;
        o_rd_cycles++;
      end
      if (!pmem_read && !pmem_write && o_wr_cycles > 0 && o_rd_cycles == 0) o_gap++;
      if (done) begin
        o_lat  = k;
        o_fill = fill_data;
        @(negedge clk);
        o_done_after = done;
        break;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          dirty;
    logic [AW-1:0] addr;
    logic [AW-1:0] vaddr;
    logic [LW-1:0] vdata;
    int            lat;
    logic [AW-1:0] exp_wr_addr;
    logic [AW-1:0] exp_rd_addr;
    logic [LW-1:0] exp_fill;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vec_t          v;
    int            busy;
    bit            flag;
    logic [LW-1:0] fill1, fill2;
    logic [AW-1:0] rd1, rd2;

    vecs[0] = '{1'b0, 16'h1234, 16'h0000, '0,                  5, 16'h0000, 16'h1220, pat(16'h1220)};
    vecs[1] = '{1'b1, 16'h0060, 16'h8040, {32{8'hA5}},         5, 16'h8040, 16'h0060, pat(16'h0060)};
    vecs[2] = '{1'b0, 16'h8047, 16'h0000, '0,                  2, 16'h0000, 16'h8040, {32{8'hA5}}};
    vecs[3] = '{1'b1, 16'h001F, 16'hFFFF, {8{32'hDEADBEEF}},   1, 16'hFFE0, 16'h0000, pat(16'h0000)};
    vecs[4] = '{1'b0, 16'hFFE5, 16'h0000, '0,                  3, 16'h0000, 16'hFFE0, {8{32'hDEADBEEF}}};
    vecs[5] = '{1'b1, 16'h7777, 16'h4321, {16{16'h5A3C}},      7, 16'h4320, 16'h7760, pat(16'h7760)};

    rst = 1'b1; req_valid = 1'b0; req_dirty = 1'b0;
    req_addr = '0; req_victim_addr = '0; req_victim_data = '0;
    #1;
    check("reset req_ready", LW'(req_ready), 1);
    check("reset pmem_read", LW'(pmem_read), 0);
    check("reset pmem_write", LW'(pmem_write), 0);
    check("reset pmem_address", LW'(pmem_address), 0);
    check("reset pmem_wdata", pmem_wdata, 0);
    check("reset done", LW'(done), 0);
    check("reset fill_data", fill_data, 0);
    check("reset err", LW'(err), 0);
    check("reset state", LW'(state_dbg), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven clean and dirty misses; request inputs are scrambled after accept.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      run_txn(v.dirty, v.addr, v.vaddr, v.vdata, v.lat);
      check($sformatf("v%0d ready before accept", i), LW'(o_ready_before), 1);
      check($sformatf("v%0d latency", i), LW'(o_lat), LW'(v.dirty ? 2 * v.lat + 2 : v.lat + 1));
      check($sformatf("v%0d fill_data", i), o_fill, v.exp_fill);
      check($sformatf("v%0d done width", i), LW'(o_done_after), 0);
      check($sformatf("v%0d read cycles", i), LW'(o_rd_cycles), LW'(v.lat));
      check($sformatf("v%0d read address", i), LW'(o_rd_addr), LW'(v.exp_rd_addr));
      check($sformatf("v%0d read addr stable", i), LW'(o_rd_unstable), 0);
      check($sformatf("v%0d write cycles", i), LW'(o_wr_cycles), LW'(v.dirty ? v.lat : 0));
      check($sformatf("v%0d gap cycles", i), LW'(o_gap), LW'(v.dirty ? 1 : 0));
      check($sformatf("v%0d strobe overlap", i), LW'(o_overlap), 0);
      check($sformatf("v%0d write before read", i), LW'(o_order_bad), 0);
      if (v.dirty) begin
        check($sformatf("v%0d write address", i), LW'(o_wr_addr), LW'(v.exp_wr_addr));
        check($sformatf("v%0d write addr stable", i), LW'(o_wr_unstable), 0);
        check($sformatf("v%0d wdata held", i), LW'(o_wdata_bad), 0);
        check($sformatf("v%0d memory writeback", i),
              mem.exists(v.exp_wr_addr) ? mem[v.exp_wr_addr] : '0, v.vdata);
      end
    end

    // Back-to-back: req_valid stays high, second address appears right after accept.
    @(negedge clk);
    mem_lat = 3; req_dirty = 1'b0; req_addr = 16'h2000; req_valid = 1'b1;
    check("b2b first ready", LW'(req_ready), 1);
    @(posedge clk);
    #1;
    req_addr = 16'h3000;
    busy = 0; fill1 = '0; rd1 = '0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) break;
      busy++;
      if (pmem_read && rd1 == '0) rd1 = pmem_address;
      if (done) fill1 = fill_data;
    end
    check("b2b busy cycles", LW'(busy), 4);
    check("b2b first read addr", LW'(rd1), LW'(16'h2000));
    check("b2b first fill", fill1, pat(16'h2000));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    fill2 = '0; rd2 = '0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pmem_read && rd2 == '0) rd2 = pmem_address;
      if (done) begin
        fill2 = fill_data;
        break;
      end
    end
    check("b2b second read addr", LW'(rd2), LW'(16'h3000));
    check("b2b second fill", fill2, pat(16'h3000));

    // Timeout: memory never answers.
    mem_en = 1'b0;
    @(negedge clk);
    req_dirty = 1'b0; req_addr = 16'h0400; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    busy = 0; flag = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pmem_read) busy++;
      if (done) flag = 1;
    end
    check("timeout strobe cycles", LW'(busy), 16);
    check("timeout no done", LW'(flag), 0);
    check("timeout err", LW'(err), 1);
    check("timeout req_ready", LW'(req_ready), 1);
    check("timeout fill kept", fill_data, pat(16'h3000));
    mem_en = 1'b1;
    run_txn(1'b0, 16'h0500, 16'h0000, '0, 2);
    check("after timeout latency", LW'(o_lat), 3);
    check("after timeout fill", o_fill, pat(16'h0500));
    check("err sticky", LW'(err), 1);

    // Asynchronous reset in the middle of a fill, then a stray response.
    @(negedge clk);
    mem_lat = 10; req_dirty = 1'b0; req_addr = 16'h0600; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset read", LW'(pmem_read), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst pmem_read", LW'(pmem_read), 0);
    check("async rst pmem_address", LW'(pmem_address), 0);
    check("async rst done", LW'(done), 0);
    check("async rst fill_data", fill_data, 0);
    check("async rst err", LW'(err), 0);
    check("async rst req_ready", LW'(req_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    mem_en = 1'b0;
    @(posedge clk);
    #2;
    manual_resp = 1'b1;
    @(posedge clk);
    #2;
    manual_resp = 1'b0;
    flag = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || pmem_read || pmem_write) flag = 1;
    end
    check("late resp ignored", LW'(flag), 0);
    check("late resp state", LW'(state_dbg), 0);
    mem_en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
